// File: rtl/player_action_encoder.sv
// Per-player button front end: debounces raw buttons, latches short presses between game
// ticks, and issues one one-hot action per tick with priority arbitration and jump lock.
module player_action_encoder #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TICK_DIV        = 16,
   parameter int JUMP_TICKS      = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] btn,
   output logic [5:0] action_out,
   output logic       tick_out,
   output logic       busy_out
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(TICK_DIV);
   localparam int JW = $clog2(JUMP_TICKS + 1);

   localparam logic [5:0] ACT_RIGHT = 6'b100000;
   localparam logic [5:0] ACT_LEFT  = 6'b010000;
   localparam logic [5:0] ACT_WAIT  = 6'b001000;
   localparam logic [5:0] ACT_JUMP  = 6'b000100;
   localparam logic [5:0] ACT_KICK  = 6'b000010;
   localparam logic [5:0] ACT_PUNCH = 6'b000001;

   logic [DW-1:0] dcnt     [6];
   logic [DW-1:0] dcnt_nxt [6];
   logic [5:0]    deb, deb_nxt, pend, req, sel;
   logic [TW-1:0] tcnt;
   logic [JW-1:0] jcnt, jcnt_nxt;
   logic          tick;

   assign tick = (tcnt == TW'(TICK_DIV - 1));
   assign req  = deb | pend;

   always_comb begin
      deb_nxt = deb;
      for (int i = 0; i < 6; i++) begin
         dcnt_nxt[i] = '0;
         if (btn[i] != deb[i]) begin
            if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1))
               deb_nxt[i] = btn[i];
            else
               dcnt_nxt[i] = dcnt[i] + 1'b1;
         end
      end
   end

   // Arbitration: an active jump lock overrides every request; left+right cancel out.
   always_comb begin
      sel      = ACT_WAIT;
      jcnt_nxt = jcnt;
      if (jcnt != '0) begin
         sel      = ACT_JUMP;
         jcnt_nxt = jcnt - 1'b1;
      end else if (req[0]) begin
         sel = ACT_PUNCH;
      end else if (req[1]) begin
         sel = ACT_KICK;
      end else if (req[2]) begin
         sel      = ACT_JUMP;
         jcnt_nxt = JW'(JUMP_TICKS - 1);
      end else if (req[4] && !req[5]) begin
         sel = ACT_LEFT;
      end else if (req[5] && !req[4]) begin
         sel = ACT_RIGHT;
      end else if (req[3]) begin
         sel = ACT_WAIT;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 6; i++) dcnt[i] <= '0;
         deb        <= '0;
         pend       <= '0;
         tcnt       <= '0;
         jcnt       <= '0;
         action_out <= ACT_WAIT;
         tick_out   <= 1'b0;
         busy_out   <= 1'b0;
      end else begin
         for (int i = 0; i < 6; i++) dcnt[i] <= dcnt_nxt[i];
         deb      <= deb_nxt;
         tcnt     <= tick ? '0 : tcnt + 1'b1;
         tick_out <= tick;
         if (tick) begin
            // A rising edge coinciding with the tick is intentionally dropped here.
            pend       <= '0;
            action_out <= sel;
            jcnt       <= jcnt_nxt;
            busy_out   <= (jcnt_nxt != '0);
         end else begin
            pend <= pend | (deb_nxt & ~deb);
         end
      end
   end

endmodule

// File: tb/tb_player_action_encoder.sv
// Scoreboard bench for player_action_encoder: stimulus pushes expected per-tick actions,
// a negedge monitor pops and compares whenever a DUT raises tick_out.
module tb_player_action_encoder;

   typedef struct {
      logic [5:0] act;
      logic       busy;
      int         at;
      string      nm;
   } exp_t;

   localparam logic [5:0] RIGHT = 6'b100000;
   localparam logic [5:0] LEFT  = 6'b010000;
   localparam logic [5:0] WAITA = 6'b001000;
   localparam logic [5:0] JUMP  = 6'b000100;
   localparam logic [5:0] KICK  = 6'b000010;
   localparam logic [5:0] PUNCH = 6'b000001;

   logic       clk = 1'b0;
   logic       rst_n, rst3_n;
   logic [5:0] btn;
   logic [5:0] action_out, action3;
   logic       tick_out, tick3, busy_out, busy3;

   int   cyc = 0;
   logic rst_q = 1'b0, rst3_q = 1'b0;
   int   n_pass = 0, n_tot = 0;
   logic final_req = 1'b0, final_done = 1'b0;
   int   r0, r1;
   exp_t q[$], q3[$];

   player_action_encoder dut (
      .clk(clk), .rst_n(rst_n), .btn(btn),
      .action_out(action_out), .tick_out(tick_out), .busy_out(busy_out)
   );

   player_action_encoder #(.JUMP_TICKS(3)) dut3 (
      .clk(clk), .rst_n(rst3_n), .btn(btn),
      .action_out(action3), .tick_out(tick3), .busy_out(busy3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      rst_q  <= rst_n;
      rst3_q <= rst3_n;
   end

   task automatic check(input string nm, input int got, input int want);
      n_tot++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, got, want, cyc);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_q)
         check("reset_state", int'({action_out, tick_out, busy_out}), int'({WAITA, 2'b00}));
      else if (tick_out) begin
         if (q.size() == 0) check("unexpected_tick", 1, 0);
         else begin
            e = q.pop_front();
            check({e.nm, "_act"}, int'(action_out), int'(e.act));
            check({e.nm, "_busy"}, int'(busy_out), int'(e.busy));
            check({e.nm, "_cycle"}, cyc, e.at);
         end
      end
      if (!rst3_q)
         check("j3_reset_state", int'({action3, tick3, busy3}), int'({WAITA, 2'b00}));
      else if (tick3) begin
         if (q3.size() == 0) check("j3_unexpected_tick", 1, 0);
         else begin
            e = q3.pop_front();
            check({e.nm, "_act"}, int'(action3), int'(e.act));
            check({e.nm, "_busy"}, int'(busy3), int'(e.busy));
            check({e.nm, "_cycle"}, cyc, e.at);
         end
      end
      if (final_req && !final_done) begin
         check("queues_drained", q.size() + q3.size(), 0);
         final_done = 1'b1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic to_cyc(input int c);
      while (cyc < c) step();
   endtask

   function automatic void exp_main(input logic [5:0] a, input logic b, input int at, input string nm);
      exp_t e;
      e.act = a; e.busy = b; e.at = at; e.nm = nm;
      q.push_back(e);
   endfunction

   function automatic void exp_j3(input logic [5:0] a, input logic b, input int at, input string nm);
      exp_t e;
      e.act = a; e.busy = b; e.at = at; e.nm = nm;
      q3.push_back(e);
   endfunction

   initial begin
      btn = '0; rst_n = 1'b0; rst3_n = 1'b0;
      repeat (3) step();
      r0 = cyc; rst_n = 1'b1;
      exp_main(WAITA, 1'b0, r0 + 16, "t1_idle");

      // 3-cycle glitch, then a real press of punch
      to_cyc(r0 + 18); btn = 6'b000001;
      to_cyc(r0 + 21); btn = 6'b000000;
      exp_main(WAITA, 1'b0, r0 + 32, "t2_glitch");
      to_cyc(r0 + 36); btn = 6'b000001;
      exp_main(PUNCH, 1'b0, r0 + 48, "t3_punch");
      to_cyc(r0 + 48); btn = 6'b000000;

      // short kick press fully debounced in and out before the tick
      to_cyc(r0 + 53); btn = 6'b000010;
      to_cyc(r0 + 59); btn = 6'b000000;
      exp_main(KICK, 1'b0, r0 + 64, "t4_short_kick");
      exp_main(WAITA, 1'b0, r0 + 80, "t5_after_kick");

      to_cyc(r0 + 81); btn = 6'b100011;
      exp_main(PUNCH, 1'b0, r0 + 96, "t6_prio");
      exp_main(PUNCH, 1'b0, r0 + 112, "t7_prio_hold");
      to_cyc(r0 + 112); btn = 6'b110000;
      exp_main(WAITA, 1'b0, r0 + 128, "t8_cancel");
      exp_main(WAITA, 1'b0, r0 + 144, "t9_cancel_hold");
      to_cyc(r0 + 144); btn = 6'b010100;
      exp_main(JUMP, 1'b1, r0 + 160, "t10_jump_over_left");
      to_cyc(r0 + 160); btn = 6'b000000;
      exp_main(JUMP, 1'b0, r0 + 176, "t11_jump_lock");
      exp_main(WAITA, 1'b0, r0 + 192, "t12_idle");

      // jump pulse then punch held; second instance has a 3-tick lock
      to_cyc(r0 + 192); rst3_n = 1'b1;
      to_cyc(r0 + 200); btn = 6'b000100;
      to_cyc(r0 + 205); btn = 6'b000001;
      exp_main(JUMP, 1'b1, r0 + 208, "t13_jump");
      exp_main(JUMP, 1'b0, r0 + 224, "t14_jump_lock");
      exp_main(PUNCH, 1'b0, r0 + 240, "t15_punch");
      exp_main(PUNCH, 1'b0, r0 + 256, "t16_punch");
      exp_j3(JUMP, 1'b1, r0 + 208, "j3_t1_jump");
      exp_j3(JUMP, 1'b1, r0 + 224, "j3_t2_lock");
      exp_j3(JUMP, 1'b0, r0 + 240, "j3_t3_lock");
      exp_j3(PUNCH, 1'b0, r0 + 256, "j3_t4_punch");

      // reset in the middle of a jump lock with punch held
      to_cyc(r0 + 256); btn = 6'b000000; rst3_n = 1'b0;
      to_cyc(r0 + 264); btn = 6'b000100;
      to_cyc(r0 + 269); btn = 6'b000001;
      exp_main(JUMP, 1'b1, r0 + 272, "t17_jump");
      to_cyc(r0 + 276); rst_n = 1'b0;
      step();
      r1 = cyc; rst_n = 1'b1;
      exp_main(PUNCH, 1'b0, r1 + 16, "t18_after_reset");

      to_cyc(r1 + 20);
      final_req = 1'b1;
      step(); step();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
